// File: rtl/prime_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : prime_div_sched
// Brief    : Trial-division sequencer for prime detection. Drives an external
//            iterative divider one divisor at a time and reports the verdict.
// Revision : 1.0 - initial release
// ============================================================================
module prime_div_sched #(
   parameter int NBITS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             istream_val,
   output logic             istream_rdy,
   input  logic [NBITS-1:0] n,
   output logic             ostream_val,
   input  logic             ostream_rdy,
   output logic             is_prime,
   output logic [NBITS-1:0] factor,
   output logic [NBITS-1:0] div_opa,
   output logic [NBITS-1:0] div_opb,
   output logic             div_istream_val,
   input  logic             div_istream_rdy,
   input  logic [NBITS-1:0] div_result,
   input  logic             div_ostream_val,
   output logic             div_ostream_rdy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [NBITS-1:0]   r_n;
   logic [NBITS-1:0]   r_d;
   logic               r_is_prime;
   logic [NBITS-1:0]   r_factor;

   logic [2*NBITS-1:0] w_n_wide;
   logic [2*NBITS-1:0] w_d_sq;
   logic [2*NBITS-1:0] w_prod;
   logic               w_small;
   logic               w_d_past_root;
   logic               w_exact;
   logic [NBITS-1:0]   w_d_next;

   // Products are formed at double width so d*d and q*d never overflow.
   assign w_n_wide      = {{NBITS{1'b0}}, r_n};
   assign w_d_sq        = {{NBITS{1'b0}}, r_d} * {{NBITS{1'b0}}, r_d};
   assign w_prod        = {{NBITS{1'b0}}, div_result} * {{NBITS{1'b0}}, r_d};
   assign w_small       = (r_n < NBITS'(2));
   assign w_d_past_root = (w_d_sq > w_n_wide);
   assign w_exact       = (w_prod == w_n_wide);
   // After 2 only odd divisors are tried.
   assign w_d_next      = (r_d == NBITS'(2)) ? NBITS'(3) : (r_d + NBITS'(2));

   assign div_opa  = r_n;
   assign div_opb  = r_d;
   assign is_prime = r_is_prime;
   assign factor   = r_factor;

   always_comb begin
      w_next          = r_state;
      istream_rdy     = 1'b0;
      ostream_val     = 1'b0;
      div_istream_val = 1'b0;
      div_ostream_rdy = 1'b0;
      case (r_state)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) w_next = CHECK;
         end
         CHECK: begin
            if (w_small || w_d_past_root) w_next = DONE;
            else                          w_next = ISSUE;
         end
         ISSUE: begin
            div_istream_val = 1'b1;
            if (div_istream_rdy) w_next = WAIT;
         end
         WAIT: begin
            div_ostream_rdy = 1'b1;
            if (div_ostream_val) w_next = w_exact ? DONE : CHECK;
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_n        <= '0;
         r_d        <= '0;
         r_is_prime <= 1'b0;
         r_factor   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (istream_val) begin
                  r_n <= n;
                  r_d <= NBITS'(2);
               end
            end
            CHECK: begin
               if (w_small) begin
                  r_is_prime <= 1'b0;
                  r_factor   <= '0;
               end else if (w_d_past_root) begin
                  r_is_prime <= 1'b1;
                  r_factor   <= '0;
               end
            end
            WAIT: begin
               if (div_ostream_val) begin
                  if (w_exact) begin
                     r_is_prime <= 1'b0;
                     r_factor   <= r_d;
                  end else begin
                     r_d <= w_d_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
